exe_muldiv: RTL

Iterative RV64M multiply/divide unit in the execute stage, directly downstream of the ID/EXE pipeline latch. Accepts an M-extension operation using the latched register operands and funct3, holds the pipeline frozen while it iterates, and returns one 64-bit result for the EXE/MEM path. Freeze is the only stall source it drives; the hazard unit ORs `stall` into the ID/EXE and upstream freeze terms.

---
 rtl/exe_muldiv.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/exe_muldiv.sv
// Iterative RV64M multiply/divide unit for the execute stage; freezes the pipeline while iterating.
// Optional MULDIV_FAST_MUL_EN: multiplies bypass CALC with a single-cycle 128-bit product.
module exe_muldiv (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  input  logic        word,
  input  logic [2:0]  funct3,
  input  logic [63:0] rs1,
  input  logic [63:0] rs2,
  input  logic        flush,
  output logic        stall,
  output logic        busy,
  output logic        done,
  output logic [63:0] result
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t        state;
  logic [2:0]    f3_q;
  logic          wd_q;
  logic          neg_q;
  logic [6:0]    cnt;
  logic [127:0]  acc;
  logic [127:0]  mcand;
  logic [63:0]   mplier;
  logic [63:0]   quo;
  logic [63:0]   rem;
  logic [63:0]   dvs;

  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  // operand decode for the op presented in IDLE
  logic          sgn1, sgn2, neg1, neg2, is_div, is_rem;
  logic          div_zero, ovf, illegal, short_op;
  logic [63:0]   op1, op2, mag1, mag2, min_val, short_res;

  always_comb begin
    is_div  = funct3[2];
    is_rem  = funct3[2] & funct3[1];
    sgn1    = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b100) || (funct3 == 3'b110);
    sgn2    = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    op1     = word ? (sgn1 ? sext32(rs1[31:0]) : {32'd0, rs1[31:0]}) : rs1;
    op2     = word ? (sgn2 ? sext32(rs2[31:0]) : {32'd0, rs2[31:0]}) : rs2;
    neg1    = sgn1 & op1[63];
    neg2    = sgn2 & op2[63];
    mag1    = neg1 ? -op1 : op1;
    mag2    = neg2 ? -op2 : op2;
    min_val = word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
    div_zero = is_div & (op2 == 64'd0);
    ovf      = is_div & ~funct3[0] & (op1 == min_val) & (op2 == {64{1'b1}});
    illegal  = word & ~funct3[2] & (funct3[1:0] != 2'b00);
    short_op = div_zero | ovf | illegal;
    short_res = 64'd0;
    if (illegal)       short_res = 64'd0;
    else if (div_zero) short_res = funct3[1] ? (word ? sext32(rs1[31:0]) : rs1) : {64{1'b1}};
    else if (ovf)      short_res = funct3[1] ? 64'd0 : min_val;
  end

  // one restoring-division step
  logic [64:0] rem_sh, diff;
  logic        ge;

  always_comb begin
    rem_sh = {rem, quo[63]};
    diff   = rem_sh - {1'b0, dvs};
    ge     = ~diff[64];
  end

  // final sign fix-up and field select
  logic [127:0] prod, p;
  logic [63:0]  q_fix, r_fix, sel, fix_res;

  always_comb begin
`ifdef MULDIV_FAST_MUL_EN
    prod = {64'd0, mcand[63:0]} * {64'd0, mplier};
`else
    prod = acc;
`endif
    p     = neg_q ? -prod : prod;
    q_fix = neg_q ? -quo : quo;
    r_fix = neg_q ? -rem : rem;
    case (f3_q)
      3'b000:                 sel = p[63:0];
      3'b001, 3'b010, 3'b011: sel = p[127:64];
      3'b100, 3'b101:         sel = q_fix;
      default:                sel = r_fix;
    endcase
    fix_res = wd_q ? sext32(sel[31:0]) : sel;
  end

  assign stall = start & ~done;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= 64'd0;
      cnt    <= 7'd0;
      f3_q   <= 3'd0;
      wd_q   <= 1'b0;
      neg_q  <= 1'b0;
      acc    <= 128'd0;
      mcand  <= 128'd0;
      mplier <= 64'd0;
      quo    <= 64'd0;
      rem    <= 64'd0;
      dvs    <= 64'd0;
    end else if (flush) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            f3_q   <= funct3;
            wd_q   <= word;
            neg_q  <= is_rem ? neg1 : (neg1 ^ neg2);
            acc    <= 128'd0;
            mcand  <= {64'd0, mag1};
            mplier <= mag2;
            // word divides start with the dividend at the top so the quotient lands in [31:0]
            quo    <= word ? {mag1[31:0], 32'd0} : mag1;
            rem    <= 64'd0;
            dvs    <= mag2;
            cnt    <= word ? 7'd31 : 7'd63;
            busy   <= 1'b1;
            if (short_op) begin
              result <= short_res;
              done   <= 1'b1;
              state  <= DONE;
            end
`ifdef MULDIV_FAST_MUL_EN
            else if (!is_div) state <= FIX;
`endif
            else state <= CALC;
          end
        end
        CALC: begin
          if (f3_q[2]) begin
            rem <= ge ? diff[63:0] : rem_sh[63:0];
            quo <= {quo[62:0], ge};
          end else begin
            acc    <= acc + (mplier[0] ? mcand : 128'd0);
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
          end
          if (cnt == 7'd0) state <= FIX;
          else             cnt   <= cnt - 7'd1;
        end
        FIX: begin
          result <= fix_res;
          done   <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
